rsa_modexp_core: RTL and testbench
==================================

// Module: rsa_modexp_core
// PURPOSE
//  Next-generation RSA datapath core: parametrised radix-2 Montgomery modular exponentiator, m = c^d mod n.
//  Adds a single modular-multiply mode, abort, and operand error detection.
//  Sits under the RSA top level: the top loads operands, pulses start, waits for done.
//  Reuses the precomputed r2_mod_n (r = 2^K, K = DATA_WIDTH+2) convention.
// PARAMETERS
//  DATA_WIDTH  9                       operand width (c, d, n, r2_mod_n, m)
//  T_WIDTH     $clog2(DATA_WIDTH)      width of t_sub_1 (localparam)
//  K           DATA_WIDTH+2            Montgomery iterations per multiply (localparam)
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous active-high reset
//  ce           in   1           clock enable; all state frozen while low
//  start        in   1           operation request; accepted when start&&ready&&ce
//  abort        in   1           cancel current operation
//  op_mul       in   1           0: m=c^d mod n; 1: m=c*d mod n
//  c            in   DATA_WIDTH  base / multiplicand, must be < n
//  d            in   DATA_WIDTH  exponent / multiplier (< n in mul mode)
//  t_sub_1      in   T_WIDTH     MSB index of d (exp mode only)
//  r2_mod_n     in   DATA_WIDTH  (2^(2K)) mod n
//  n            in   DATA_WIDTH  modulus, odd, >= 3
//  ready        out  1           core idle and able to accept start
//  busy         out  1           operation in progress
//  m            out  DATA_WIDTH  result, valid when done; held until next done
//  done         out  1           one-cycle completion pulse
//  err          out  1           qualifies done: operands rejected
// BEHAVIOUR
//  Reset: ready=1, busy=0, m=0, done=0, err=0, state IDLE.
//  All inputs are captured on the accepting edge; later input changes are ignored.
//  MM(a,b) = a*b*2^-K mod 2n: S=0; K steps of S=(S+a[i]*b+q*n)>>1, q=LSB(S+a[i]*b).
//   One MM takes K+1 cycles (1 load + K steps). No intermediate subtraction; final result gets one conditional subtract.
//  FSM: IDLE -> CHK -> PRE -> {SQR,MUL}* -> POST -> FIN -> IDLE.
//   CHK (1 cycle): n even, n<3 or t_sub_1>=DATA_WIDTH -> done=1, err=1, m=0 next cycle, back to IDLE.
//   PRE: cb=MM(c,r2_mod_n).
//   exp mode: x=cb; for i=t_sub_1-1 downto 0: SQR x=MM(x,x); if d[i] MUL x=MM(x,cb).
//    d[t_sub_1] is treated as 1; bits above t_sub_1 are ignored.
//   POST: exp mode x=MM(x,1); mul mode x=MM(cb,d).
//   FIN (1 cycle): m = (x>=n) ? x-n : x; done=1, err=0.
//  Latency from accepting edge to done-high cycle, ce held high:
//   exp: (2+t_sub_1+popcount(d[t_sub_1-1:0]))*(K+1)+1+1 (CHK); mul: 2*(K+1)+2.
//  ready=1 only in IDLE; busy=~ready except in OFF. start while busy is ignored.
//  abort (ce high): any state -> IDLE next cycle, no done, m unchanged. abort+start in IDLE: abort wins.
//  ce low: FSM, counters, datapath and outputs hold; a done pulse is stretched until ce returns.
//  rst mid-operation: immediate return to reset values, no done.
//  Operands c>=n or r2_mod_n wrong: done still pulses after nominal latency; m unspecified; err=0.
// CONFIGURATION
//  RSA_PWR_CTRL_EN defined:
//   Adds ports req_enable and req_disable (in, 1), plus state OFF.
//   req_disable honoured only in IDLE -> OFF next cycle: ready=0, busy=0, m retained.
//   In OFF, start is ignored; req_enable -> IDLE next cycle, ready=1.
//   req_disable while busy is ignored (not queued). Reset always lands in IDLE (powered on).
//  RSA_PWR_CTRL_EN undefined: ports absent, no OFF state, core always on.
// TESTING (DATA_WIDTH=9, K=11)
//  T1 exp c=255,d=4,n=511,t_sub_1=2,r2=16 -> m=32, err=0, done exactly 4*12+2=50 cycles after accept.
//  T2 exp back-to-back:
//   c=56,d=5,n=509,t=2,r2=144 -> m=393;
//   then d=1,t=0 -> 56; then c=0 -> 0; then c=1 -> 1;
//   then c=45,d=5,n=225,r2=79 -> 0.
//  T3 mul c=200,d=300,n=509,r2=144 -> m=447 after 26 cycles; n=510 -> done+err=1,m=0 2 cycles after accept.
//  T4 abort 10 cycles into T1: no done, ready=1 next cycle, m keeps prior value; immediate rerun of T1 -> 32.
//  T5 ce toggled 1-of-3 during T1 -> m=32, done after 3x latency; start while busy ignored.
//  T6 (RSA_PWR_CTRL_EN) req_disable in IDLE -> ready=0, start ignored;
//   req_enable -> ready=1, T1 passes; req_disable mid-T1 ignored.

Source files
------------

// File: rtl/rsa_modexp_core_if.sv
// Operand, handshake and status bundle for rsa_modexp_core.
// The req_enable/req_disable power requests exist only when RSA_PWR_CTRL_EN is defined.
interface rsa_modexp_core_if #(
    parameter int DATA_WIDTH = 9
);
    localparam int T_WIDTH = $clog2(DATA_WIDTH);

    logic                  ce;
    logic                  start;
    logic                  abort;
    logic                  op_mul;
    logic [DATA_WIDTH-1:0] c;
    logic [DATA_WIDTH-1:0] d;
    logic [T_WIDTH-1:0]    t_sub_1;
    logic [DATA_WIDTH-1:0] r2_mod_n;
    logic [DATA_WIDTH-1:0] n;
    logic                  ready;
    logic                  busy;
    logic [DATA_WIDTH-1:0] m;
    logic                  done;
    logic                  err;
`ifdef RSA_PWR_CTRL_EN
    logic                  req_enable;
    logic                  req_disable;

    modport master (
        output ce, start, abort, op_mul, c, d, t_sub_1, r2_mod_n, n, req_enable, req_disable,
        input  ready, busy, m, done, err
    );
    modport slave (
        input  ce, start, abort, op_mul, c, d, t_sub_1, r2_mod_n, n, req_enable, req_disable,
        output ready, busy, m, done, err
    );
`else
    modport master (
        output ce, start, abort, op_mul, c, d, t_sub_1, r2_mod_n, n,
        input  ready, busy, m, done, err
    );
    modport slave (
        input  ce, start, abort, op_mul, c, d, t_sub_1, r2_mod_n, n,
        output ready, busy, m, done, err
    );
`endif
endinterface

// File: rtl/rsa_modexp_core.sv
// Radix-2 Montgomery core: m = c^d mod n (op_mul=0) or m = c*d mod n (op_mul=1).
// Defining RSA_PWR_CTRL_EN adds an OFF state driven by req_disable/req_enable.
module rsa_modexp_core #(
    parameter int DATA_WIDTH = 9
) (
    input logic              clk,
    input logic              rst,
    rsa_modexp_core_if.slave bus
);
    localparam int T_WIDTH = $clog2(DATA_WIDTH);
    localparam int K       = DATA_WIDTH + 2;
    localparam int CW      = $clog2(K + 1);
    localparam int SW      = DATA_WIDTH + 2;
    localparam logic [CW-1:0]    K_LAST  = CW'(K);
    localparam logic [T_WIDTH:0] T_LIMIT = (T_WIDTH + 1)'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE, CHK, PRE, SQR, MUL, POST, FIN
`ifdef RSA_PWR_CTRL_EN
        , OFF
`endif
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic                  op_mul_r, chk_fail, done_r, err_r;
    logic [DATA_WIDTH-1:0] c_r, d_r, r2_r, n_r, m_r;
    logic [T_WIDTH-1:0]    t_r, bit_idx;
    logic [SW-1:0]         s, a_sh, b_r, cb, s_step, s_red, n_ext;
    logic [SW:0]           sum_ab;
    logic                  in_mm, mm_last, operands_bad, accept;

    assign n_ext        = SW'(n_r);
    assign in_mm        = (state == PRE) || (state == SQR) || (state == MUL) || (state == POST);
    assign mm_last      = in_mm && (cnt == K_LAST);
    assign operands_bad = !n_r[0] || (n_r < DATA_WIDTH'(3)) || ({1'b0, t_r} >= T_LIMIT);
    assign accept       = (state == IDLE) && (state_next == CHK);

    // With n odd and S+a_i*b odd, (S+a_i*b+n)/2 = (S+a_i*b)>>1 + (n>>1) + 1, so no wide add is needed
    always_comb begin
        sum_ab = {1'b0, s} + (a_sh[0] ? {1'b0, b_r} : '0);
        s_step = sum_ab[SW:1] + (sum_ab[0] ? SW'(n_r[DATA_WIDTH-1:1]) + SW'(1) : '0);
        s_red  = (s >= n_ext) ? s - n_ext : s;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) state_next = CHK;
`ifdef RSA_PWR_CTRL_EN
                if (bus.req_disable) state_next = OFF;
`endif
            end
            CHK:  state_next = operands_bad ? FIN : PRE;
            PRE:  if (mm_last) state_next = (op_mul_r || t_r == '0) ? POST : SQR;
            SQR: begin
                if (mm_last) begin
                    if (d_r[bit_idx])         state_next = MUL;
                    else if (bit_idx == '0)   state_next = POST;
                end
            end
            MUL:  if (mm_last) state_next = (bit_idx == '0) ? POST : SQR;
            POST: if (mm_last) state_next = FIN;
            FIN:  state_next = IDLE;
`ifdef RSA_PWR_CTRL_EN
            OFF:  if (bus.req_enable) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
        if (bus.abort) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)         state <= IDLE;
        else if (bus.ce) state <= state_next;
    end

    // Each multiply spends cnt==0 loading operands, then K shift/accumulate steps
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            op_mul_r <= 1'b0;
            chk_fail <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            c_r      <= '0;
            d_r      <= '0;
            r2_r     <= '0;
            n_r      <= '0;
            m_r      <= '0;
            t_r      <= '0;
            bit_idx  <= '0;
            s        <= '0;
            a_sh     <= '0;
            b_r      <= '0;
            cb       <= '0;
        end else if (bus.ce) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            cnt    <= (in_mm && !mm_last && !bus.abort) ? cnt + 1'b1 : '0;
            if (accept) begin
                op_mul_r <= bus.op_mul;
                c_r      <= bus.c;
                d_r      <= bus.d;
                t_r      <= bus.t_sub_1;
                r2_r     <= bus.r2_mod_n;
                n_r      <= bus.n;
            end
            if (state == CHK) chk_fail <= operands_bad;
            if (in_mm && cnt == '0) begin
                s <= '0;
                case (state)
                    PRE: begin
                        a_sh <= SW'(c_r);
                        b_r  <= SW'(r2_r);
                    end
                    SQR: begin
                        a_sh <= s;
                        b_r  <= s;
                    end
                    MUL: begin
                        a_sh <= s;
                        b_r  <= cb;
                    end
                    default: begin
                        a_sh <= op_mul_r ? cb : s;
                        b_r  <= op_mul_r ? SW'(d_r) : SW'(1);
                    end
                endcase
            end else if (in_mm) begin
                s    <= s_step;
                a_sh <= a_sh >> 1;
            end
            if (state == PRE && mm_last) begin
                cb      <= s_step;
                bit_idx <= t_r - 1'b1;
            end
            if (state == SQR && mm_last && !d_r[bit_idx] && bit_idx != '0) bit_idx <= bit_idx - 1'b1;
            if (state == MUL && mm_last && bit_idx != '0) bit_idx <= bit_idx - 1'b1;
            if (state == FIN && !bus.abort) begin
                done_r <= 1'b1;
                err_r  <= chk_fail;
                m_r    <= chk_fail ? '0 : s_red[DATA_WIDTH-1:0];
            end
        end
    end

    assign bus.ready = (state == IDLE);
`ifdef RSA_PWR_CTRL_EN
    assign bus.busy  = (state != IDLE) && (state != OFF);
`else
    assign bus.busy  = (state != IDLE);
`endif
    assign bus.m     = m_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed self-checking bench for rsa_modexp_core (DATA_WIDTH=9, K=11).
// Power-control scenario runs only when RSA_PWR_CTRL_EN is defined.
module tb_rsa_modexp_core;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    rsa_modexp_core_if #(.DATA_WIDTH(9)) bus ();
    rsa_modexp_core #(.DATA_WIDTH(9)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Present operands, let the next edge accept them, then scramble the inputs
    task automatic start_op(input logic mul, input logic [8:0] cv, input logic [8:0] dv,
                            input logic [3:0] tv, input logic [8:0] r2v, input logic [8:0] nv);
        bus.op_mul   = mul;
        bus.c        = cv;
        bus.d        = dv;
        bus.t_sub_1  = tv;
        bus.r2_mod_n = r2v;
        bus.n        = nv;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.c        = ~cv;
        bus.d        = ~dv;
        bus.r2_mod_n = ~r2v;
        bus.n        = ~nv;
        bus.op_mul   = ~mul;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.ce       = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.op_mul   = 1'b0;
        bus.c        = '0;
        bus.d        = '0;
        bus.t_sub_1  = '0;
        bus.r2_mod_n = '0;
        bus.n        = '0;
`ifdef RSA_PWR_CTRL_EN
        bus.req_enable  = 1'b0;
        bus.req_disable = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.m !== 9'd0) begin errors++; $display("[TB] FAIL reset_m: got %0d expected 0", bus.m); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_exp_basic();
        int cyc;
        start_op(1'b0, 9'd255, 9'd4, 4'd2, 9'd16, 9'd511);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL t1_busy: got %b expected 1", bus.busy); end
        wait_done(200, cyc);
        checks++; if (cyc !== 50) begin errors++; $display("[TB] FAIL t1_latency: got %0d expected 50", cyc); end
        checks++; if (bus.m !== 9'd32) begin errors++; $display("[TB] FAIL t1_m: got %0d expected 32", bus.m); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL t1_err: got %b expected 0", bus.err); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL t1_done_pulse: got %b expected 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] tc [0:4] = '{9'd56, 9'd56, 9'd0, 9'd1, 9'd45};
        logic [8:0] td [0:4] = '{9'd5, 9'd1, 9'd1, 9'd1, 9'd5};
        logic [3:0] tt [0:4] = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd2};
        logic [8:0] tr [0:4] = '{9'd144, 9'd144, 9'd144, 9'd144, 9'd79};
        logic [8:0] tn [0:4] = '{9'd509, 9'd509, 9'd509, 9'd509, 9'd225};
        logic [8:0] te [0:4] = '{9'd393, 9'd56, 9'd0, 9'd1, 9'd0};
        int         tl [0:4] = '{62, 26, 26, 26, 62};
        int cyc;
        for (int i = 0; i < 5; i++) begin
            start_op(1'b0, tc[i], td[i], tt[i], tr[i], tn[i]);
            wait_done(200, cyc);
            checks++; if (cyc !== tl[i]) begin errors++; $display("[TB] FAIL t2_latency[%0d]: got %0d expected %0d", i, cyc, tl[i]); end
            checks++; if (bus.m !== te[i]) begin errors++; $display("[TB] FAIL t2_m[%0d]: got %0d expected %0d", i, bus.m, te[i]); end
        end
    endtask

    task automatic test_mul();
        int cyc;
        start_op(1'b1, 9'd200, 9'd300, 4'd0, 9'd144, 9'd509);
        wait_done(100, cyc);
        checks++; if (cyc !== 26) begin errors++; $display("[TB] FAIL t3_latency: got %0d expected 26", cyc); end
        checks++; if (bus.m !== 9'd447) begin errors++; $display("[TB] FAIL t3_m: got %0d expected 447", bus.m); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL t3_err: got %b expected 0", bus.err); end
        start_op(1'b1, 9'd200, 9'd300, 4'd0, 9'd144, 9'd510);
        wait_done(10, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("[TB] FAIL t3_even_latency: got %0d expected 2", cyc); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL t3_even_err: got %b expected 1", bus.err); end
        checks++; if (bus.m !== 9'd0) begin errors++; $display("[TB] FAIL t3_even_m: got %0d expected 0", bus.m); end
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL t3_even_pulse: got %b expected 0", bus.done); end
    endtask

    task automatic test_abort();
        int cyc;
        bit seen;
        start_op(1'b1, 9'd200, 9'd300, 4'd0, 9'd144, 9'd509);
        wait_done(100, cyc);
        checks++; if (bus.m !== 9'd447) begin errors++; $display("[TB] FAIL t4_pre_m: got %0d expected 447", bus.m); end
        start_op(1'b0, 9'd255, 9'd4, 4'd2, 9'd16, 9'd511);
        repeat (9) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL t4_ready: got %b expected 1", bus.ready); end
        checks++; if (bus.m !== 9'd447) begin errors++; $display("[TB] FAIL t4_m_kept: got %0d expected 447", bus.m); end
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL t4_no_done: got %b expected 0", seen); end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL t4_abort_wins: got %b expected 1", bus.ready); end
        start_op(1'b0, 9'd255, 9'd4, 4'd2, 9'd16, 9'd511);
        wait_done(200, cyc);
        checks++; if (cyc !== 50) begin errors++; $display("[TB] FAIL t4_rerun_latency: got %0d expected 50", cyc); end
        checks++; if (bus.m !== 9'd32) begin errors++; $display("[TB] FAIL t4_rerun_m: got %0d expected 32", bus.m); end
    endtask

    task automatic test_ce_gating();
        int cyc;
        cyc = -1;
        start_op(1'b0, 9'd255, 9'd4, 4'd2, 9'd16, 9'd511);
        for (int k = 1; k <= 200; k++) begin
            bus.ce = ((k % 3) == 0);
            if (k == 30) begin
                bus.start = 1'b1;
                bus.op_mul = 1'b1;
                bus.c = 9'd3;
                bus.d = 9'd5;
                bus.n = 9'd7;
            end
            @(posedge clk);
            #1;
            if (k == 30) begin
                bus.start = 1'b0;
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL t5_busy: got %b expected 1", bus.busy); end
            end
            if (bus.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        checks++; if (cyc !== 150) begin errors++; $display("[TB] FAIL t5_latency: got %0d expected 150", cyc); end
        checks++; if (bus.m !== 9'd32) begin errors++; $display("[TB] FAIL t5_m: got %0d expected 32", bus.m); end
        bus.ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL t5_stretch: got %b expected 1", bus.done); end
        bus.ce = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL t5_release: got %b expected 0", bus.done); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL t5_ready: got %b expected 1", bus.ready); end
    endtask

`ifdef RSA_PWR_CTRL_EN
    task automatic test_power();
        int cyc;
        bus.req_disable = 1'b1;
        @(posedge clk);
        #1;
        bus.req_disable = 1'b0;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL t6_off_ready: got %b expected 0", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL t6_off_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.m !== 9'd32) begin errors++; $display("[TB] FAIL t6_off_m: got %0d expected 32", bus.m); end
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL t6_start_ignored: got %b expected 0", bus.busy); end
        bus.req_enable = 1'b1;
        @(posedge clk);
        #1;
        bus.req_enable = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL t6_on_ready: got %b expected 1", bus.ready); end
        start_op(1'b0, 9'd255, 9'd4, 4'd2, 9'd16, 9'd511);
        cyc = -1;
        for (int k = 1; k <= 200; k++) begin
            bus.req_disable = (k == 5);
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        bus.req_disable = 1'b0;
        checks++; if (cyc !== 50) begin errors++; $display("[TB] FAIL t6_latency: got %0d expected 50", cyc); end
        checks++; if (bus.m !== 9'd32) begin errors++; $display("[TB] FAIL t6_m: got %0d expected 32", bus.m); end
        @(posedge clk);
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL t6_not_queued: got %b expected 1", bus.ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_exp_basic();
        test_back_to_back();
        test_mul();
        test_abort();
        test_ce_gating();
`ifdef RSA_PWR_CTRL_EN
        test_power();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
